// File: rtl/fp_mul_scheduler_pkg.sv
// Shared types and constants for the two-requester FP multiplier scheduler.
package fp_mul_sched_pkg;

    localparam int FP_WIDTH = 32;
    localparam logic [FP_WIDTH-1:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [FP_WIDTH-1:0] FP_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_OPA   = 3'd2,
        S_OPB   = 3'd3,
        S_WAIT  = 3'd4,
        S_RESB  = 3'd5
    } sched_state_e;

    typedef struct packed {
        logic [FP_WIDTH-1:0] op1;
        logic [FP_WIDTH-1:0] op2;
    } op_pair_t;

endpackage

// File: rtl/fp_mul_scheduler_if.sv
// Requester, response and multiplier-core signals between the scheduler and its environment.
interface fp_mul_scheduler_if;
    import fp_mul_sched_pkg::*;

    logic                req0_valid;
    logic                req1_valid;
    logic [FP_WIDTH-1:0] req0_op1;
    logic [FP_WIDTH-1:0] req0_op2;
    logic [FP_WIDTH-1:0] req1_op1;
    logic [FP_WIDTH-1:0] req1_op2;
    logic                req0_ready;
    logic                req1_ready;

    logic                rsp0_valid;
    logic                rsp1_valid;
    logic [FP_WIDTH-1:0] rsp0_res;
    logic [FP_WIDTH-1:0] rsp1_res;
    logic                rsp0_err;
    logic                rsp1_err;

    logic                mul_ready;
    logic [FP_WIDTH-1:0] mul_op1;
    logic [FP_WIDTH-1:0] mul_op2;
    logic [FP_WIDTH-1:0] mul_res;
    logic                mul_done;

    // Scheduler side.
    modport slave (
        input  req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp0_res, rsp1_res, rsp0_err, rsp1_err,
        output mul_ready, mul_op1, mul_op2,
        input  mul_res, mul_done
    );

    // Requesters plus multiplier core.
    modport master (
        output req0_valid, req1_valid, req0_op1, req0_op2, req1_op1, req1_op2,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp0_res, rsp1_res, rsp0_err, rsp1_err,
        input  mul_ready, mul_op1, mul_op2,
        output mul_res, mul_done
    );

endinterface

// File: rtl/fp_mul_scheduler_watchdog.sv
// Up-counter of cycles spent waiting on the core; expires on the last allowed cycle.
module fp_mul_watchdog #(
    parameter int DONE_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(DONE_TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The increment in this cycle brings the count to DONE_TIMEOUT.
    assign expire_o = en_i && (count_q == LAST);

endmodule

// File: rtl/fp_mul_scheduler.sv
// Batches up to two requests into one dispatch of a shared two-slot FP multiplier
// and routes each product back to its owner as a single-cycle response.
//
// state | meaning
// IDLE  | ready to accept; latches operands of any valid requester
// START | one-cycle start pulse to the core
// OPA   | slot A operands on mul_op*
// OPB   | slot B operands on mul_op* (zero for a dummy slot)
// WAIT  | waiting for mul_done; watchdog running
// RESB  | slot B result on mul_res
module fp_mul_scheduler
    import fp_mul_sched_pkg::*;
#(
    parameter int DONE_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    fp_mul_scheduler_if.slave   bus
);

    sched_state_e state_q, state_d;
    logic         rr_q, rr_d;
    op_pair_t     a_q, a_d;
    op_pair_t     b_q, b_d;
    logic         a_owner_q, a_owner_d;
    logic         b_live_q, b_live_d;

    logic [1:0]               rsp_valid_q, rsp_valid_d;
    logic [1:0]               rsp_err_q, rsp_err_d;
    logic [1:0][FP_WIDTH-1:0] rsp_res_q, rsp_res_d;

    logic     wd_expire;
    logic     in_wait;
    logic     acc0, acc1;
    op_pair_t req0_pair, req1_pair;

    assign in_wait   = (state_q == S_WAIT);
    assign req0_pair = '{op1: bus.req0_op1, op2: bus.req0_op2};
    assign req1_pair = '{op1: bus.req1_op1, op2: bus.req1_op2};
    assign acc0      = bus.req0_valid && bus.req0_ready;
    assign acc1      = bus.req1_valid && bus.req1_ready;

    fp_mul_watchdog #(
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!in_wait),
        .en_i     (in_wait),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        a_d         = a_q;
        b_d         = b_q;
        a_owner_d   = a_owner_q;
        b_live_d    = b_live_q;
        rsp_valid_d = '0;
        rsp_err_d   = rsp_err_q;
        rsp_res_d   = rsp_res_q;

        case (state_q)
            S_IDLE: begin
                if (acc0 && acc1) begin
                    a_owner_d = rr_q;
                    a_d       = rr_q ? req1_pair : req0_pair;
                    b_d       = rr_q ? req0_pair : req1_pair;
                    b_live_d  = 1'b1;
                    rr_d      = ~rr_q;
                    state_d   = S_START;
                end else if (acc0 || acc1) begin
                    a_owner_d = acc1;
                    a_d       = acc1 ? req1_pair : req0_pair;
                    b_d       = '0;
                    b_live_d  = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: state_d = S_OPA;
            S_OPA:   state_d = S_OPB;
            S_OPB:   state_d = S_WAIT;
            S_WAIT: begin
                if (bus.mul_done) begin
                    rsp_valid_d[a_owner_q] = 1'b1;
                    rsp_err_d[a_owner_q]   = 1'b0;
                    rsp_res_d[a_owner_q]   = bus.mul_res;
                    state_d                = S_RESB;
                end else if (wd_expire) begin
                    rsp_valid_d[a_owner_q] = 1'b1;
                    rsp_err_d[a_owner_q]   = 1'b1;
                    rsp_res_d[a_owner_q]   = FP_QNAN;
                    if (b_live_q) begin
                        rsp_valid_d[~a_owner_q] = 1'b1;
                        rsp_err_d[~a_owner_q]   = 1'b1;
                        rsp_res_d[~a_owner_q]   = FP_QNAN;
                    end
                    state_d = S_IDLE;
                end
            end
            S_RESB: begin
                // A dummy slot B result is dropped without touching either port.
                if (b_live_q) begin
                    rsp_valid_d[~a_owner_q] = 1'b1;
                    rsp_err_d[~a_owner_q]   = 1'b0;
                    rsp_res_d[~a_owner_q]   = bus.mul_res;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            a_owner_q   <= 1'b0;
            b_live_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_res_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_owner_q   <= a_owner_d;
            b_live_q    <= b_live_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_res_q   <= rsp_res_d;
        end
    end

    // Ready is held low while reset is asserted so nothing is accepted or advertised.
    assign bus.req0_ready = (state_q == S_IDLE) && !rst;
    assign bus.req1_ready = (state_q == S_IDLE) && !rst;

    assign bus.mul_ready = (state_q == S_START);
    assign bus.mul_op1   = (state_q == S_OPA) ? a_q.op1 :
                           (state_q == S_OPB) ? b_q.op1 : FP_ZERO;
    assign bus.mul_op2   = (state_q == S_OPA) ? a_q.op2 :
                           (state_q == S_OPB) ? b_q.op2 : FP_ZERO;

    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp0_err   = rsp_err_q[0];
    assign bus.rsp1_err   = rsp_err_q[1];
    assign bus.rsp0_res   = rsp_res_q[0];
    assign bus.rsp1_res   = rsp_res_q[1];

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Directed cycle-scripted bench for fp_mul_scheduler; the bench plays requesters and core.
module tb_fp_mul_scheduler;

    localparam logic [31:0] A16_25 = 32'h4182_0000;
    localparam logic [31:0] A9     = 32'h4110_0000;
    localparam logic [31:0] P146   = 32'h4312_4000;
    localparam logic [31:0] B22    = 32'h41B0_0000;
    localparam logic [31:0] BM5    = 32'hC0A0_0000;
    localparam logic [31:0] PM110  = 32'hC2DC_0000;
    localparam logic [31:0] C2     = 32'h4000_0000;
    localparam logic [31:0] C3     = 32'h4040_0000;
    localparam logic [31:0] P6     = 32'h40C0_0000;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cnt0   = 0;
    int   cnt1   = 0;
    int   snap0, snap1;

    fp_mul_scheduler_if bus ();

    fp_mul_scheduler #(
        .DONE_TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.rsp0_valid) cnt0++;
            if (bus.rsp1_valid) cnt1++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_req(input logic v0, input logic [31:0] a1, input logic [31:0] a2,
                             input logic v1, input logic [31:0] b1, input logic [31:0] b2);
        bus.req0_valid = v0;
        bus.req0_op1   = a1;
        bus.req0_op2   = a2;
        bus.req1_valid = v1;
        bus.req1_op1   = b1;
        bus.req1_op2   = b2;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic core(input logic done, input logic [31:0] res);
        bus.mul_done = done;
        bus.mul_res  = res;
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_op1   = '0;
        bus.req0_op2   = '0;
        bus.req1_op1   = '0;
        bus.req1_op2   = '0;
        bus.mul_done   = 1'b0;
        bus.mul_res    = '0;

        tick(2);
        check("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check("rst_ready1", 32'(bus.req1_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("init_ready0", 32'(bus.req0_ready), 32'd1);
        check("init_ready1", 32'(bus.req1_ready), 32'd1);
        check("init_rsp", 32'({bus.rsp0_valid, bus.rsp1_valid, bus.mul_ready}), 32'd0);

        // Single request from req0; core answers three cycles into WAIT's lead-in.
        drive_req(1'b1, A16_25, A9, 1'b0, 32'h0, 32'h0);
        check("t1_mul_ready", 32'(bus.mul_ready), 32'd1);
        check("t1_busy_ready0", 32'(bus.req0_ready), 32'd0);
        tick();
        check("t1_opa_op1", bus.mul_op1, A16_25);
        check("t1_opa_op2", bus.mul_op2, A9);
        check("t1_opa_start_low", 32'(bus.mul_ready), 32'd0);
        tick();
        check("t1_opb_op1", bus.mul_op1, 32'h0);
        check("t1_opb_op2", bus.mul_op2, 32'h0);
        tick();
        check("t1_wait_op1", bus.mul_op1, 32'h0);
        tick(2);
        core(1'b1, P146);
        tick();
        core(1'b0, 32'hDEAD_BEEF);
        check("t1_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("t1_rsp0_res", bus.rsp0_res, P146);
        check("t1_rsp0_err", 32'(bus.rsp0_err), 32'd0);
        check("t1_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        tick();
        core(1'b0, 32'h0);
        check("t1_rsp0_pulse_end", 32'(bus.rsp0_valid), 32'd0);
        check("t1_idle_ready0", 32'(bus.req0_ready), 32'd1);
        check("t1_cnt0", 32'(cnt0), 32'd1);
        check("t1_cnt1", 32'(cnt1), 32'd0);

        // Both requesters, rr=0: req0 in slot A.
        drive_req(1'b1, A16_25, A9, 1'b1, B22, BM5);
        tick();
        check("t2_opa_op1", bus.mul_op1, A16_25);
        tick();
        check("t2_opb_op1", bus.mul_op1, B22);
        check("t2_opb_op2", bus.mul_op2, BM5);
        tick();
        core(1'b1, P146);
        tick();
        core(1'b0, PM110);
        check("t2_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("t2_rsp0_res", bus.rsp0_res, P146);
        check("t2_rsp1_early", 32'(bus.rsp1_valid), 32'd0);
        tick();
        core(1'b0, 32'h0);
        check("t2_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        check("t2_rsp1_res", bus.rsp1_res, PM110);
        check("t2_rsp0_late", 32'(bus.rsp0_valid), 32'd0);
        check("t2_idle_ready1", 32'(bus.req1_ready), 32'd1);

        // Same pair again, rr=1: req1 in slot A and answered first.
        drive_req(1'b1, A16_25, A9, 1'b1, B22, BM5);
        tick();
        check("t2b_opa_op1", bus.mul_op1, B22);
        tick();
        check("t2b_opb_op1", bus.mul_op1, A16_25);
        tick();
        core(1'b1, PM110);
        tick();
        core(1'b0, P146);
        check("t2b_rsp1_first", 32'(bus.rsp1_valid), 32'd1);
        check("t2b_rsp1_res", bus.rsp1_res, PM110);
        check("t2b_rsp0_early", 32'(bus.rsp0_valid), 32'd0);
        tick();
        core(1'b0, 32'h0);
        check("t2b_rsp0_second", 32'(bus.rsp0_valid), 32'd1);
        check("t2b_rsp0_res", bus.rsp0_res, P146);

        // NaN pass-through on req1 alone.
        drive_req(1'b0, 32'h0, 32'h0, 1'b1, 32'hFF80_0006, 32'h3FA0_0000);
        tick();
        check("t3_opa_op1", bus.mul_op1, 32'hFF80_0006);
        tick(3);
        core(1'b1, 32'hFF80_0006);
        tick();
        core(1'b0, 32'h1234_5678);
        check("t3_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        check("t3_rsp1_res", bus.rsp1_res, 32'hFF80_0006);
        check("t3_rsp1_err", 32'(bus.rsp1_err), 32'd0);
        tick();
        core(1'b0, 32'h0);
        check("t3_dummy_rsp0", 32'(bus.rsp0_valid), 32'd0);
        check("t3_rsp0_held", bus.rsp0_res, P146);

        // Spurious done during START/OPA/OPB must be ignored.
        snap0 = cnt0;
        bus.req0_valid = 1'b1;
        bus.req0_op1   = C2;
        bus.req0_op2   = C3;
        tick();
        bus.req0_valid = 1'b0;
        core(1'b1, 32'h1111_1111);
        tick(3);
        core(1'b0, 32'h0);
        tick();
        check("t4_no_early_rsp", 32'(cnt0 - snap0), 32'd0);
        check("t4_rsp0_quiet", 32'(bus.rsp0_valid), 32'd0);
        tick();
        core(1'b1, P6);
        tick();
        core(1'b0, 32'h0);
        check("t4_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("t4_rsp0_res", bus.rsp0_res, P6);
        tick();

        // Watchdog abort, both slots live, DONE_TIMEOUT=8: WAIT spans 8 cycles.
        drive_req(1'b1, A16_25, A9, 1'b1, B22, BM5);
        tick(10);
        check("t5_no_early_abort", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
        tick();
        check("t5_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("t5_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        check("t5_rsp0_err", 32'(bus.rsp0_err), 32'd1);
        check("t5_rsp1_err", 32'(bus.rsp1_err), 32'd1);
        check("t5_rsp0_res", bus.rsp0_res, QNAN);
        check("t5_rsp1_res", bus.rsp1_res, QNAN);
        tick();
        check("t5_ready0", 32'(bus.req0_ready), 32'd1);
        check("t5_ready1", 32'(bus.req1_ready), 32'd1);
        check("t5_pulse_end", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);

        // Reset mid-WAIT (rr=1 before reset), with done arriving during reset.
        snap0 = cnt0;
        snap1 = cnt1;
        drive_req(1'b1, A16_25, A9, 1'b0, 32'h0, 32'h0);
        tick(4);
        rst = 1'b1;
        core(1'b1, 32'h2222_2222);
        tick();
        check("t6_rst_ctrl", 32'({bus.req0_ready, bus.req1_ready, bus.mul_ready,
                                 bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_err, bus.rsp1_err}), 32'd0);
        check("t6_rst_op1", bus.mul_op1, 32'h0);
        check("t6_rst_op2", bus.mul_op2, 32'h0);
        check("t6_rst_res0", bus.rsp0_res, 32'h0);
        check("t6_rst_res1", bus.rsp1_res, 32'h0);
        tick();
        rst = 1'b0;
        core(1'b0, 32'h0);
        tick(6);
        check("t6_no_rsp0", 32'(cnt0 - snap0), 32'd0);
        check("t6_no_rsp1", 32'(cnt1 - snap1), 32'd0);

        // Fresh pair after reset: rr back to 0, so req0 takes slot A.
        drive_req(1'b1, C2, C3, 1'b1, B22, BM5);
        tick();
        check("t6_opa_op1", bus.mul_op1, C2);
        tick(2);
        core(1'b1, P6);
        tick();
        core(1'b0, PM110);
        check("t6_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("t6_rsp0_res", bus.rsp0_res, P6);
        tick();
        core(1'b0, 32'h0);
        check("t6_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        check("t6_rsp1_res", bus.rsp1_res, PM110);
        check("t6_rsp1_err", 32'(bus.rsp1_err), 32'd0);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_mul_scheduler.md
# fp_mul_scheduler

Shares one two-slot IEEE754 single-precision multiplier core between two requesters. Each requester presents an operand pair; the scheduler batches up to two pending requests into one multiplier dispatch, sequences the core's start/operand/done protocol, and returns each product to its owner as a one-cycle response pulse. It sits between the requester logic and the multiplier core, and a watchdog aborts a dispatch whose `done` never arrives.

## Interface
- `DONE_TIMEOUT`, 64: maximum cycles spent in WAIT before abort; legal range 2..1023.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: requester has an operand pair.
- `req0_op1`, `req0_op2` / `req1_op1`, `req1_op2` in 32: operands (IEEE754 single).
- `req0_ready` / `req1_ready` out 1: request accepted when valid & ready.
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle result pulse; no backpressure.
- `rsp0_res` / `rsp1_res` out 32: product; held until next pulse for that port.
- `rsp0_err` / `rsp1_err` out 1: qualifies rspN_valid; 1 = watchdog abort.
- `mul_ready` out 1: start pulse to core.
- `mul_op1`, `mul_op2` out 32: operands to core.
- `mul_res` in 32: core result.
- `mul_done` in 1: core done; result A on the `done` cycle, result B on the next cycle.

## Operation
- States: IDLE, START, OPA, OPB, WAIT, RESB.
- IDLE: `req0_ready = req1_ready = 1`. Any accepted request latches operands and moves to START; with no request it stays in IDLE.
- Slot assignment:
  - Both requesters valid: slot A gets requester `rr`, slot B gets the other, then `rr` toggles.
  - One requester valid: it takes slot A; slot B is a dummy (operands 0x00000000, `b_live=0`); `rr` is unchanged.
- START: `mul_ready=1` for exactly one cycle.
- OPA: drive slot A operands. OPB: drive slot B operands.
- Outside OPA and OPB, `mul_op1`/`mul_op2` are 0.
- WAIT: the cycle counter increments every cycle.
  - `mul_done=1`: register `mul_res` into slot A's response port, pulse its valid, go to RESB.
  - Counter reaches DONE_TIMEOUT: abort. Pulse valid with `err=1` and `res=0x7FC00000` on slot A's port, and on slot B's port if `b_live`; go to IDLE.
- RESB: register `mul_res` into slot B's port and pulse its valid if `b_live`; otherwise discard. Go to IDLE.
- `mul_done` outside WAIT is ignored.
- The scheduler never modifies products; special values (NaN, inf, zero) pass through bit-exact.
- Reset (any state, including mid-dispatch): state=IDLE, `rr=0`, counter=0, latched operands cleared; in-flight requests are dropped with no response.
- Reset values of all outputs are 0 except `reqN_ready`, which is 1 from the first non-reset cycle.

## Timing
- `reqN_ready` and `mul_*` outputs are Moore-decoded from the state register; `rspN_*` are registered.
- Accept at cycle 0 (IDLE) -> `mul_ready` in cycle 1 -> slot A operands in cycle 2 -> slot B operands in cycle 3 -> WAIT from cycle 4.
- `mul_done` seen in cycle T: slot A `rsp` valid in T+1, slot B `rsp` valid in T+2, IDLE in T+2.
- Earliest next accept is T+2.
- Abort: `err` pulses appear the cycle after the counter reaches DONE_TIMEOUT; both pulses fall in the same cycle.
- A requester is never re-accepted before its own response pulse.

## Structure
- `fp_mul_sched_pkg`: state enum, `FP_QNAN = 32'h7FC00000`, `FP_WIDTH = 32`.
- Sub-module `fp_mul_watchdog`: counter with clear/enable/expire; its width is derived from DONE_TIMEOUT.
- Top level holds the FSM, slot latches, round-robin bit and response registers.

## Test plan
- Single request, core model with 3-cycle done latency: req0 `0x41820000 x 0x41100000` -> `rsp0_res=0x43124000`, `err=0`, `rsp1_valid` never pulses, `mul_op` slot B = 0.
- Simultaneous requests, `rr=0`: req0 `0x41820000 x 0x41100000` and req1 `0x41B00000 x 0xC0A00000` -> `rsp0=0x43124000` at T+1, `rsp1=0xC2DC0000` at T+2. Repeating the pair -> req1 takes slot A and its response pulses first.
- Pass-through: req1 `0xFF800006 x 0x3FA00000` with core returning `0xFF800006` -> `rsp1_res=0xFF800006` bit-exact.
- Timeout, DONE_TIMEOUT=8, core never raises done, both requests live -> both `rspN_err=1`, `res=0x7FC00000` in the same cycle; `reqN_ready=1` in the next cycle.
- Reset asserted during WAIT -> no `rsp` pulse ever; all outputs 0 during reset; a fresh request afterward completes normally.
- Spurious `mul_done` during START/OPA/OPB -> ignored; the response is taken only from `done` seen in WAIT.
